// File: rtl/gcbp_subimage_write_ctrl_if.sv
// rtl/gcbp_subimage_write_ctrl_if.sv - pixel stream handshake bundle for the GCBP subimage writer
interface gcbp_subimage_write_ctrl_if #(
  parameter int PIX_W = 8
);
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_eol;

  modport master (output pix_valid, pix_data, pix_sof, pix_eol, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/gcbp_subimage_write_ctrl.sv
// rtl/gcbp_subimage_write_ctrl.sv - scatters a raster pixel stream into the 4x4 GCBP subimage BRAMs
// Optional error counter output is enabled by defining GCBP_WR_ERR_CNT_EN.
module gcbp_subimage_write_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  gcbp_subimage_write_ctrl_if.slave s_pix,
  output logic [15:0]          o_bram_array_wea,
  output logic [ADDR_W-1:0]    o_bram_addr,
  output logic [PIX_W-1:0]     o_bram_din,
  output logic [1:0]           o_vert_sub_cnt,
  output logic [1:0]           o_hori_sub_cnt,
  output logic                 o_frame_done,
  input  logic                 i_frame_ack,
  output logic                 o_sync_err
`ifdef GCBP_WR_ERR_CNT_EN
  ,
  output logic [7:0]           o_err_cnt
`endif
);

  localparam int SUB_W = IMG_W / 4;
  localparam int SUB_H = IMG_H / 4;
  localparam int SC_W  = (SUB_W > 1) ? $clog2(SUB_W) : 1;
  localparam int SR_W  = (SUB_H > 1) ? $clog2(SUB_H) : 1;
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SUB_W - 1);
  localparam logic [SR_W-1:0]   SR_LAST  = SR_W'(SUB_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SUB_W);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic [SC_W-1:0]   r_sub_col;
  logic [1:0]        r_hori;
  logic [SR_W-1:0]   r_sub_row;
  logic [1:0]        r_vert;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_pix_ready;
  logic [15:0]       r_wea;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_din;
  logic [1:0]        r_vsub, r_hsub;
  logic              r_frame_done;
  logic              r_sync_err;

  logic              w_beat, w_accept, w_sof, w_eol;
  logic [SC_W-1:0]   w_cur_col;
  logic [1:0]        w_cur_hori;
  logic [SR_W-1:0]   w_cur_row;
  logic [1:0]        w_cur_vert;
  logic [ADDR_W-1:0] w_cur_base;
  logic              w_last_col, w_last_sub_row, w_last_row, w_line_end;
  logic              w_viol, w_frame_end;
  logic [15:0]       w_wea_dec;

  // A sof beat is always placed at pixel (0,0), whether it opens a frame or restarts one.
  always_comb begin
    w_sof          = s_pix.pix_sof;
    w_eol          = s_pix.pix_eol;
    w_beat         = s_pix.pix_valid & r_pix_ready;
    w_accept       = w_beat && ((r_state == S_WRITE) || (r_state == S_IDLE && w_sof));
    w_cur_col      = w_sof ? '0 : r_sub_col;
    w_cur_hori     = w_sof ? '0 : r_hori;
    w_cur_row      = w_sof ? '0 : r_sub_row;
    w_cur_vert     = w_sof ? '0 : r_vert;
    w_cur_base     = w_sof ? '0 : r_row_base;
    w_last_col     = (w_cur_col == SC_LAST) && (w_cur_hori == 2'd3);
    w_last_sub_row = (w_cur_row == SR_LAST);
    w_last_row     = w_last_sub_row && (w_cur_vert == 2'd3);
    w_line_end     = w_eol || w_last_col;
    w_viol         = w_accept && ((w_eol != w_last_col) || (w_sof && r_state == S_WRITE));
    w_frame_end    = w_accept && w_line_end && w_last_row;
    w_wea_dec      = 16'd1 << {w_cur_vert, w_cur_hori};
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_frame_end ? S_DONE : S_WRITE;
      S_WRITE: if (w_frame_end) w_next_state = S_DONE;
      S_DONE:  if (i_frame_ack) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sub_col    <= '0;
      r_hori       <= '0;
      r_sub_row    <= '0;
      r_vert       <= '0;
      r_row_base   <= '0;
      r_pix_ready  <= 1'b0;
      r_wea        <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_vsub       <= '0;
      r_hsub       <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pix_ready  <= (w_next_state != S_DONE);
      r_frame_done <= (r_state == S_DONE) && (w_next_state == S_DONE);
      r_wea        <= w_accept ? w_wea_dec : '0;
      if (w_viol) r_sync_err <= 1'b1;
      if (w_accept) begin
        r_addr <= w_cur_base + ADDR_W'(w_cur_col);
        r_din  <= s_pix.pix_data;
        r_vsub <= w_cur_vert;
        r_hsub <= w_cur_hori;
        // Counters cascade sub_col -> hori on a column step, sub_row -> vert on a line end.
        if (w_line_end) begin
          r_sub_col <= '0;
          r_hori    <= '0;
          if (w_last_row) begin
            r_sub_row  <= '0;
            r_vert     <= '0;
            r_row_base <= '0;
          end else if (w_last_sub_row) begin
            r_sub_row  <= '0;
            r_row_base <= '0;
            r_vert     <= w_cur_vert + 2'd1;
          end else begin
            r_sub_row  <= w_cur_row + 1'b1;
            r_row_base <= w_cur_base + ROW_STEP;
            r_vert     <= w_cur_vert;
          end
        end else if (w_cur_col == SC_LAST) begin
          r_sub_col  <= '0;
          r_hori     <= w_cur_hori + 2'd1;
          r_sub_row  <= w_cur_row;
          r_vert     <= w_cur_vert;
          r_row_base <= w_cur_base;
        end else begin
          r_sub_col  <= w_cur_col + 1'b1;
          r_hori     <= w_cur_hori;
          r_sub_row  <= w_cur_row;
          r_vert     <= w_cur_vert;
          r_row_base <= w_cur_base;
        end
      end
    end
  end

`ifdef GCBP_WR_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_err_cnt <= '0;
    else if (w_viol && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign o_err_cnt = r_err_cnt;
`endif

  assign s_pix.pix_ready  = r_pix_ready;
  assign o_bram_array_wea = r_wea;
  assign o_bram_addr      = r_addr;
  assign o_bram_din       = r_din;
  assign o_vert_sub_cnt   = r_vsub;
  assign o_hori_sub_cnt   = r_hsub;
  assign o_frame_done     = r_frame_done;
  assign o_sync_err       = r_sync_err;

endmodule
